// File: rtl/cal.sv
// Six-digit BCD key calculator: operand entry, single-cycle add/sub/mul/div,
// and a registered seven-segment BCD display word.
`timescale 1ns/1ps
module cal (
  input  logic        clk_1khz,
  input  logic        rst,
  input  logic        flag,
  input  logic [3:0]  data,
  output logic [23:0] seg_data
);

  // state  | meaning
  // IN_A   | entering operand A
  // IN_B   | operator latched, entering operand B
  // RESULT | showing A op B
  // ERROR  | divide by zero, display all F
  typedef enum logic [1:0] {IN_A, IN_B, RESULT, ERROR} state_t;

  localparam logic [3:0] KEY_EQ  = 4'd10;
  localparam logic [3:0] KEY_CLR = 4'd11;
  localparam logic [1:0] OP_ADD  = 2'd0;
  localparam logic [1:0] OP_SUB  = 2'd1;
  localparam logic [1:0] OP_MUL  = 2'd2;
  localparam logic [2:0] MAX_DIG = 3'd6;

  state_t      state_q, state_d;
  logic [19:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [2:0]  cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
  logic [1:0]  op_q, op_d;
  logic        neg_q, neg_d;
  logic [23:0] disp;

  logic [20:0] sum;
  logic [19:0] add_res, sub_res, mul_res, div_res;
  logic [39:0] prod;
  logic [39:0] prod_mod;

  function automatic logic [19:0] append(input logic [19:0] v, input logic [3:0] d);
    logic [23:0] t;
    t = {4'd0, v} * 24'd10 + {20'd0, d};
    return t[19:0];
  endfunction

  function automatic logic [23:0] to_bcd(input logic [19:0] v);
    logic [19:0] r;
    logic [19:0] digit;
    logic [23:0] out;
    r   = v;
    out = '0;
    for (int i = 0; i < 6; i++) begin
      digit        = r % 20'd10;
      out[4*i +: 4] = digit[3:0];
      r            = r / 20'd10;
    end
    return out;
  endfunction

  // All arithmetic settles combinationally so '=' resolves in one clock.
  always_comb begin
    sum      = {1'b0, a_q} + {1'b0, b_q};
    add_res  = (sum >= 21'd1000000) ? 20'(sum - 21'd1000000) : sum[19:0];
    sub_res  = (a_q >= b_q) ? (a_q - b_q) : (b_q - a_q);
    prod     = {20'd0, a_q} * {20'd0, b_q};
    prod_mod = prod % 40'd1000000;
    mul_res  = prod_mod[19:0];
    div_res  = (b_q == 20'd0) ? 20'd0 : (a_q / b_q);
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cnt_a_d = cnt_a_q;
    cnt_b_d = cnt_b_q;
    op_d    = op_q;
    neg_d   = neg_q;
    if (flag) begin
      if (data == KEY_CLR) begin
        state_d = IN_A;
        a_d     = '0;
        b_d     = '0;
        res_d   = '0;
        cnt_a_d = '0;
        cnt_b_d = '0;
        op_d    = '0;
        neg_d   = 1'b0;
      end else if (data <= 4'd9) begin
        case (state_q)
          IN_A: if (cnt_a_q < MAX_DIG) begin
            a_d     = append(a_q, data);
            cnt_a_d = cnt_a_q + 3'd1;
          end
          IN_B: if (cnt_b_q < MAX_DIG) begin
            b_d     = append(b_q, data);
            cnt_b_d = cnt_b_q + 3'd1;
          end
          default: begin
            state_d = IN_A;
            a_d     = {16'd0, data};
            cnt_a_d = 3'd1;
            b_d     = '0;
            cnt_b_d = '0;
          end
        endcase
      end else if (data == KEY_EQ) begin
        if (state_q == IN_B) begin
          state_d = RESULT;
          neg_d   = 1'b0;
          case (op_q)
            OP_ADD: res_d = add_res;
            OP_SUB: begin
              res_d = sub_res;
              neg_d = (a_q < b_q);
            end
            OP_MUL: res_d = mul_res;
            default: begin
              res_d = div_res;
              if (b_q == 20'd0) state_d = ERROR;
            end
          endcase
        end
      end else begin
        case (state_q)
          IN_A: begin
            state_d = IN_B;
            op_d    = data[1:0];
            b_d     = '0;
            cnt_b_d = '0;
          end
          IN_B: op_d = data[1:0];
          RESULT: begin
            state_d = IN_B;
            op_d    = data[1:0];
            a_d     = neg_q ? 20'd0 : res_q;
            b_d     = '0;
            cnt_b_d = '0;
          end
          default: ;
        endcase
      end
    end
  end

  // B only replaces A on the display once its first digit arrives.
  always_comb begin
    disp = '0;
    case (state_q)
      IN_A:   disp = to_bcd(a_q);
      IN_B:   disp = (cnt_b_q != 3'd0) ? to_bcd(b_q) : to_bcd(a_q);
      RESULT: begin
        disp = to_bcd(res_q);
        if (neg_q) disp[23:20] = 4'hA;
      end
      default: disp = 24'hFFFFFF;
    endcase
  end

  always_ff @(posedge clk_1khz) begin
    if (rst) begin
      state_q  <= IN_A;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      cnt_a_q  <= '0;
      cnt_b_q  <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      seg_data <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      cnt_a_q  <= cnt_a_d;
      cnt_b_q  <= cnt_b_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      seg_data <= disp;
    end
  end

endmodule

// File: tb/tb_cal.sv
// Bench for cal: directed scenarios with literal expectations plus random
// key streams checked every cycle against an arithmetic calculator model.
`timescale 1ns/1ps
module tb_cal;

  logic        clk_1khz = 1'b0;
  logic        rst      = 1'b1;
  logic        flag     = 1'b0;
  logic [3:0]  data     = 4'd0;
  logic [23:0] seg_data;

  cal dut (
    .clk_1khz (clk_1khz),
    .rst      (rst),
    .flag     (flag),
    .data     (data),
    .seg_data (seg_data)
  );

  always #5 clk_1khz = ~clk_1khz;

  int n_cmp = 0;
  int n_bad = 0;
  bit check_en = 1'b0;
  logic [23:0] exp_seg = '0;

  // Calculator model: mode 0=entering A, 1=entering B, 2=result, 3=error.
  int     m_mode = 0;
  longint m_a = 0, m_b = 0, m_res = 0;
  int     m_na = 0, m_nb = 0, m_op = 0;
  bit     m_neg = 1'b0;

  function automatic logic [23:0] bcd6(input longint v);
    logic [23:0] r;
    longint x;
    x = v;
    r = '0;
    for (int i = 0; i < 6; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [23:0] model_disp();
    logic [23:0] r;
    case (m_mode)
      0: r = bcd6(m_a);
      1: r = (m_nb > 0) ? bcd6(m_b) : bcd6(m_a);
      2: begin
        if (m_neg) begin
          r = bcd6(m_res % 100000);
          r[23:20] = 4'hA;
        end else r = bcd6(m_res);
      end
      default: r = 24'hFFFFFF;
    endcase
    return r;
  endfunction

  task automatic model_clear();
    m_mode = 0; m_a = 0; m_b = 0; m_res = 0;
    m_na = 0; m_nb = 0; m_op = 0; m_neg = 1'b0;
  endtask

  task automatic model_key(input int k);
    if (k == 11) model_clear();
    else if (k < 10) begin
      if (m_mode == 0) begin
        if (m_na < 6) begin m_a = m_a * 10 + k; m_na++; end
      end else if (m_mode == 1) begin
        if (m_nb < 6) begin m_b = m_b * 10 + k; m_nb++; end
      end else begin
        m_mode = 0; m_a = k; m_na = 1; m_b = 0; m_nb = 0;
      end
    end else if (k == 10) begin
      if (m_mode == 1) begin
        m_mode = 2;
        m_neg = 1'b0;
        case (m_op)
          0: m_res = (m_a + m_b) % 1000000;
          1: begin
            m_neg = (m_a < m_b);
            m_res = m_neg ? (m_b - m_a) : (m_a - m_b);
          end
          2: m_res = (m_a * m_b) % 1000000;
          default: begin
            if (m_b == 0) m_mode = 3;
            else m_res = m_a / m_b;
          end
        endcase
      end
    end else begin
      if (m_mode == 0) begin
        m_op = k - 12; m_b = 0; m_nb = 0; m_mode = 1;
      end else if (m_mode == 1) m_op = k - 12;
      else if (m_mode == 2) begin
        m_a = m_neg ? 0 : m_res;
        m_op = k - 12; m_b = 0; m_nb = 0; m_mode = 1;
      end
    end
  endtask

  // Display lags the model state by one edge; reset clears it on the same edge.
  initial forever begin
    @(posedge clk_1khz);
    if (rst) begin
      exp_seg = '0;
      model_clear();
    end else begin
      exp_seg = model_disp();
      if (flag) model_key(int'(data));
    end
  end

  initial forever begin
    @(negedge clk_1khz);
    if (check_en) begin
      n_cmp++;
      if (seg_data !== exp_seg) begin
        n_bad++;
        $display("FAIL cycle_check t=%0t seg_data=%06h expected=%06h", $time, seg_data, exp_seg);
      end
    end
  end

  task automatic check_lit(input string name, input logic [23:0] lit);
    n_cmp++;
    if (seg_data !== lit) begin
      n_bad++;
      $display("FAIL %s dut seg_data=%06h expected=%06h", name, seg_data, lit);
    end
    n_cmp++;
    if (exp_seg !== lit) begin
      n_bad++;
      $display("FAIL %s model display=%06h expected=%06h", name, exp_seg, lit);
    end
  endtask

  task automatic press(input int k);
    data = 4'(k);
    flag = 1'b1;
    @(negedge clk_1khz);
    flag = 1'b0;
    @(negedge clk_1khz);
  endtask

  task automatic keys(input int k0, input int k1, input int k2,
                      input int k3, input int k4, input int k5);
    int seq[6];
    seq = '{k0, k1, k2, k3, k4, k5};
    for (int i = 0; i < 6; i++) if (seq[i] >= 0) press(seq[i]);
  endtask

  initial begin
    @(negedge clk_1khz);
    check_en = 1'b1;
    repeat (9) @(negedge clk_1khz);
    rst = 1'b0;
    @(negedge clk_1khz);
    check_lit("s1_reset", 24'h000000);

    keys(5, 2, -1, -1, -1, -1);   check_lit("s2_52", 24'h000052);
    press(13);                    check_lit("s2_op_keeps_a", 24'h000052);
    keys(2, 2, -1, -1, -1, -1);   check_lit("s2_b22", 24'h000022);
    press(10);                    check_lit("s2_sub", 24'h000030);

    data = 4'd11; flag = 1'b1;
    repeat (10) @(negedge clk_1khz);
    flag = 1'b0;
    @(negedge clk_1khz);
    check_lit("s3_clear_held", 24'h000000);
    keys(4, 0, 13, 1, 2, 10);     check_lit("s3_sub", 24'h000028);

    press(11);
    keys(1, 2, 14, 1, 2, 10);     check_lit("s4_mul", 24'h000144);
    keys(12, 6, 10, -1, -1, -1);  check_lit("s4_chain", 24'h000150);

    press(11);
    keys(2, 13, 9, 10, -1, -1);   check_lit("s5_neg", 24'hA00007);
    press(12);                    check_lit("s5_neg_as_a", 24'h000000);
    keys(3, 10, -1, -1, -1, -1);  check_lit("s5_chain", 24'h000003);

    press(11);
    keys(8, 15, 0, 10, -1, -1);   check_lit("s6_div0", 24'hFFFFFF);
    press(12);                    check_lit("s6_op_ignored", 24'hFFFFFF);
    press(7);                     check_lit("s6_digit_exit", 24'h000007);

    press(11);
    keys(1, 2, 3, 4, 5, 6);
    press(7);                     check_lit("seven_digits", 24'h123456);
    press(10);                    check_lit("eq_in_a", 24'h123456);

    press(11);
    keys(9, 9, 9, 9, 9, 9);
    keys(14, 2, 10, -1, -1, -1);  check_lit("mul_wrap", 24'h999998);
    keys(12, 5, 10, -1, -1, -1);  check_lit("add_wrap", 24'h000003);

    press(11);
    keys(0, 13, 9, 9, 9, 9);
    keys(9, 9, 10, -1, -1, -1);   check_lit("neg_wrap", 24'hA99999);
    press(15); keys(4, 10, -1, -1, -1, -1);
    check_lit("neg_div", 24'h000000);

    press(11);
    keys(9, 9, 15, 7, 10, -1);    check_lit("div_trunc", 24'h000014);

    press(3);
    rst = 1'b1; flag = 1'b1; data = 4'd5;
    @(negedge clk_1khz);
    rst = 1'b0; flag = 1'b0;
    @(negedge clk_1khz);
    check_lit("reset_mid_entry", 24'h000000);

    for (int c = 0; c < 6000; c++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 55)      data = 4'($urandom_range(0, 9));
      else if (r < 68) data = 4'd10;
      else if (r < 71) data = 4'd11;
      else             data = 4'($urandom_range(12, 15));
      flag = ($urandom_range(0, 2) != 0);
      rst  = ($urandom_range(0, 399) == 0);
      @(negedge clk_1khz);
    end
    rst = 1'b0; flag = 1'b0;
    repeat (3) @(negedge clk_1khz);
    check_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
